// File: rtl/door_pkg.sv
// Shared types, default timing constants and counter reload helper for the
// door motion sequencer.
package door_pkg;

  typedef enum logic [2:0] {
    S_CLOSED     = 3'd0,
    S_DEAD_OPEN  = 3'd1,
    S_OPENING    = 3'd2,
    S_OPEN_HOLD  = 3'd3,
    S_DEAD_CLOSE = 3'd4,
    S_CLOSING    = 3'd5,
    S_FAULT      = 3'd6
  } state_t;

  localparam int unsigned DEF_HOLD_CYCLES = 1000;
  localparam int unsigned DEF_DEAD_CYCLES = 4;
  localparam int unsigned DEF_TRAVEL_MAX  = 5000;
  localparam int unsigned DEF_DB_CYCLES   = 3;
  localparam int unsigned DEF_CNT_W       = 16;

  // Value the shared counter takes on entry to a state (or on a hold refresh).
  function automatic int unsigned cnt_reload(state_t s, int unsigned hold,
                                             int unsigned dead, int unsigned travel);
    case (s)
      S_DEAD_OPEN, S_DEAD_CLOSE: return dead;
      S_OPENING, S_CLOSING:      return travel;
      S_OPEN_HOLD:               return hold;
      default:                   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/door_debounce.sv
// Limit-switch conditioner: 2-FF synchronizer followed by a stability counter.
// The accepted level changes only after DB_CYCLES equal consecutive samples.
module door_debounce
  import door_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_pin,
  output logic o_level
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;

  // Synchronize the pin and accept a new level once it has been stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (i_en) begin
      r_sync <= {r_sync[0], i_pin};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/door_motion_sched.sv
// Door motion sequencer: turns open/close requests into dead-time protected
// motor commands with auto-close, obstruction reversal and travel timeout.
module door_motion_sched
  import door_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int unsigned TRAVEL_MAX  = DEF_TRAVEL_MAX,
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       req_sensor,
  input  logic       req_open_btn,
  input  logic       req_close_btn,
  input  logic       lim_open,
  input  logic       lim_closed,
  input  logic       obstruct,
  output logic       motor_open,
  output logic       motor_close,
  output logic [2:0] state_o,
  output logic       fault
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_lim_open, w_lim_closed;
  logic             w_open_req, w_expired, w_reload;

  door_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_open (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (ena),
    .i_pin  (lim_open),
    .o_level(w_lim_open)
  );

  door_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_closed (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (ena),
    .i_pin  (lim_closed),
    .o_level(w_lim_closed)
  );

  assign w_open_req = req_sensor | req_open_btn;
  // Expiry is taken on the last counted cycle (count==1), so each timed phase
  // lasts exactly its loaded number of cycles.
  assign w_expired  = (r_cnt <= CNT_W'(1));

  // State and shared counter registers; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLOSED;
      r_cnt   <= '0;
    end else if (ena) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter update, limit conflict has top priority.
  always_comb begin
    w_state_nxt = r_state;
    w_reload    = 1'b0;
    w_cnt_nxt   = r_cnt;
    if (w_lim_open && w_lim_closed) begin
      w_state_nxt = S_FAULT;
    end else begin
      case (r_state)
        S_CLOSED:     if (w_open_req) w_state_nxt = S_DEAD_OPEN;
        S_DEAD_OPEN:  if (w_expired) w_state_nxt = S_OPENING;
        S_DEAD_CLOSE: begin
          if (obstruct || w_open_req) w_state_nxt = S_DEAD_OPEN;
          else if (w_expired)         w_state_nxt = S_CLOSING;
        end
        S_OPENING: begin
          if (w_lim_open)     w_state_nxt = S_OPEN_HOLD;
          else if (w_expired) w_state_nxt = S_FAULT;
        end
        S_OPEN_HOLD: begin
          if (obstruct || w_open_req)       w_reload    = 1'b1;
          else if (req_close_btn || w_expired) w_state_nxt = S_DEAD_CLOSE;
        end
        S_CLOSING: begin
          if (obstruct || w_open_req) w_state_nxt = S_DEAD_OPEN;
          else if (w_lim_closed)      w_state_nxt = S_CLOSED;
          else if (w_expired)         w_state_nxt = S_FAULT;
        end
        default:      w_state_nxt = S_FAULT;
      endcase
    end
    if ((w_state_nxt != r_state) || w_reload)
      w_cnt_nxt = CNT_W'(cnt_reload(w_state_nxt, HOLD_CYCLES, DEAD_CYCLES, TRAVEL_MAX));
    else if (r_cnt != '0)
      w_cnt_nxt = r_cnt - 1'b1;
    else
      w_cnt_nxt = '0;
  end

  // Outputs decoded from registered state only; ena gates the motor drive.
  always_comb begin
    motor_open  = ena && (r_state == S_OPENING);
    motor_close = ena && (r_state == S_CLOSING);
    state_o     = r_state;
    fault       = (r_state == S_FAULT);
  end

endmodule
